// File: rtl/decode_pkg.sv
// Shared decode types: opcode constants, class enum, packet struct and the
// pure decode helpers used by the decode stage.
package decode_pkg;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I_OP = 7'b0010011;
  localparam logic [6:0] OPC_I_LD = 7'b0000011;
  localparam logic [6:0] OPC_U    = 7'b0110111;
  localparam logic [6:0] OPC_B    = 7'b1100011;
  localparam logic [6:0] OPC_J    = 7'b1101111;
  localparam logic [6:0] OPC_S    = 7'b0100011;

  localparam logic [3:0] MW_NONE = 4'b0000;
  localparam logic [3:0] MW_B    = 4'b0001;
  localparam logic [3:0] MW_H    = 4'b0011;
  localparam logic [3:0] MW_W    = 4'b1111;

  typedef enum logic [2:0] {
    OC_R, OC_I_OP, OC_I_LD, OC_U, OC_B, OC_J, OC_S, OC_ILLEGAL
  } opcode_class_t;

  // XLEN-wide fields sit beside this struct in the pipe, since a package type
  // cannot follow the module's XLEN parameter.
  typedef struct packed {
    logic [4:0]    rd;
    logic          rd_write;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    opcode_class_t opclass;
    logic          mem_read;
    logic          mem_write;
    logic          mem_zero_extend;
    logic [3:0]    mem_width;
    logic          branch;
    logic          jump;
    logic          bp_taken;
    logic          illegal;
  } decode_pkt_t;

  function automatic opcode_class_t classify(input logic [6:0] opc);
    case (opc)
      OPC_R:    return OC_R;
      OPC_I_OP: return OC_I_OP;
      OPC_I_LD: return OC_I_LD;
      OPC_U:    return OC_U;
      OPC_B:    return OC_B;
      OPC_J:    return OC_J;
      OPC_S:    return OC_S;
      default:  return OC_ILLEGAL;
    endcase
  endfunction

  function automatic logic uses_rs1(input opcode_class_t c);
    return !(c == OC_U || c == OC_J);
  endfunction

  function automatic logic uses_rs2(input opcode_class_t c);
    return (c == OC_R || c == OC_B || c == OC_S);
  endfunction

  function automatic logic [3:0] width_enc(input logic [1:0] size);
    case (size)
      2'b00:   return MW_B;
      2'b01:   return MW_H;
      default: return MW_W;
    endcase
  endfunction

  // 32-bit immediate, already sign-extended from instruction bit 31.
  function automatic logic [31:0] imm_field(input logic [31:0] ins);
    case (classify(ins[6:0]))
      OC_I_OP, OC_I_LD: return {{20{ins[31]}}, ins[31:20]};
      OC_S:    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OC_B:    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OC_U:    return {ins[31:12], 12'b0};
      OC_J:    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  function automatic decode_pkt_t decode_fields(input logic [31:0] ins);
    decode_pkt_t p;
    p                 = '0;
    p.opclass         = classify(ins[6:0]);
    p.funct3          = ins[14:12];
    p.funct7          = ins[31:25];
    p.illegal         = (p.opclass == OC_ILLEGAL);
    p.rd_write        = p.opclass inside {OC_R, OC_I_OP, OC_I_LD, OC_U, OC_J};
    p.rd              = p.rd_write ? ins[11:7] : 5'd0;
    p.rs1             = uses_rs1(p.opclass) ? ins[19:15] : 5'd0;
    p.rs2             = uses_rs2(p.opclass) ? ins[24:20] : 5'd0;
    p.mem_read        = (p.opclass == OC_I_LD);
    p.mem_write       = (p.opclass == OC_S);
    p.mem_zero_extend = p.mem_read & ins[14];
    p.mem_width       = (p.mem_read | p.mem_write) ? width_enc(ins[13:12]) : MW_NONE;
    p.branch          = (p.opclass == OC_B);
    p.jump            = (p.opclass == OC_J);
    return p;
  endfunction

endpackage

// File: rtl/decode_pipe_regfile.sv
// Private register file: two combinational read ports, one write port,
// optional same-cycle write-back forwarding.
module regfile_bypass #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [4:0]      i_rd_a,
  input  logic [4:0]      i_rd_b,
  output logic [XLEN-1:0] o_data_a,
  output logic [XLEN-1:0] o_data_b,
  input  logic            i_we,
  input  logic [4:0]      i_wr_addr,
  input  logic [XLEN-1:0] i_wr_data
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] r_mem [NREGS];

  // x0 and indices beyond the file are hardwired to zero.
  function automatic logic in_range(input logic [4:0] a);
    return (a != 5'd0) && (int'(a) < NREGS);
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_we && in_range(i_wr_addr)) begin
      r_mem[i_wr_addr[AW-1:0]] <= i_wr_data;
    end
  end

  always_comb begin
    o_data_a = '0;
    o_data_b = '0;
    if (in_range(i_rd_a))
      o_data_a = (BYPASS_EN && i_we && i_wr_addr == i_rd_a) ? i_wr_data : r_mem[i_rd_a[AW-1:0]];
    if (in_range(i_rd_b))
      o_data_b = (BYPASS_EN && i_we && i_wr_addr == i_rd_b) ? i_wr_data : r_mem[i_rd_b[AW-1:0]];
  end

endmodule

// File: rtl/decode_pipe.sv
// Handshaked RV32I-subset decode stage with private register file, load-use
// stall, flush, and operand refresh while the output slot is held.
module decode_pipe
  import decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter bit BYPASS_EN = 1'b1,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic            req,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            bp_taken_in,
  input  logic            flush,
  input  logic [4:0]      wb_rd,
  input  logic            wb_write,
  input  logic [XLEN-1:0] wb_value,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [4:0]      rd_out,
  output logic            rd_write_out,
  output logic [4:0]      rs1_out,
  output logic [4:0]      rs2_out,
  output logic [XLEN-1:0] rs1_value_out,
  output logic [XLEN-1:0] rs2_value_out,
  output logic [XLEN-1:0] imm_value_out,
  output logic [2:0]      funct3_out,
  output logic [6:0]      funct7_out,
  output logic [2:0]      opclass_out,
  output logic            mem_read_out,
  output logic            mem_write_out,
  output logic            mem_zero_extend_out,
  output logic [3:0]      mem_width_out,
  output logic            branch_out,
  output logic            jump_out,
  output logic            bp_taken_out,
  output logic            illegal_out
);
  decode_pkt_t     w_pkt;
  logic [XLEN-1:0] w_imm, w_rs1_val, w_rs2_val;
  logic            w_hazard, w_accept, w_hold, w_wb_live, w_refresh1, w_refresh2;

  decode_pkt_t     r_pkt;
  logic            r_valid;
  logic [XLEN-1:0] r_pc, r_rs1_val, r_rs2_val, r_imm;

  always_comb begin
    w_pkt          = decode_fields(instr_in);
    w_pkt.bp_taken = bp_taken_in;
  end

  assign w_imm = XLEN'($signed(imm_field(instr_in)));

  regfile_bypass #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS_EN(BYPASS_EN)) u_rf (
    .i_clk     (req),
    .i_rst_n   (reset),
    .i_rd_a    (w_pkt.rs1),
    .i_rd_b    (w_pkt.rs2),
    .o_data_a  (w_rs1_val),
    .o_data_b  (w_rs2_val),
    .i_we      (wb_write),
    .i_wr_addr (wb_rd),
    .i_wr_data (wb_value)
  );

  // Unused sources decode to index 0, so comparing them against a non-zero
  // load destination only matches registers the instruction really reads.
  assign w_hazard = HAZARD_EN && r_valid && r_pkt.mem_read && (r_pkt.rd != 5'd0) &&
                    ((w_pkt.rs1 == r_pkt.rd) || (w_pkt.rs2 == r_pkt.rd));

  // Valid/ready: input transfers on in_valid & in_ready; the slot transfers on
  // out_valid & out_ready. Neither side may retract a raised valid.
  assign in_ready = reset && !flush && !w_hazard && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_hold   = r_valid && !out_ready;

  assign w_wb_live  = wb_write && (wb_rd != 5'd0) && (int'(wb_rd) < NREGS);
  assign w_refresh1 = w_wb_live && (wb_rd == r_pkt.rs1);
  assign w_refresh2 = w_wb_live && (wb_rd == r_pkt.rs2);

  always_ff @(posedge req or negedge reset) begin
    if (!reset) begin
      r_valid   <= 1'b0;
      r_pkt     <= '0;
      r_pc      <= '0;
      r_rs1_val <= '0;
      r_rs2_val <= '0;
      r_imm     <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_pkt     <= w_pkt;
      r_pc      <= pc_in;
      r_rs1_val <= w_rs1_val;
      r_rs2_val <= w_rs2_val;
      r_imm     <= w_imm;
    end else if (w_hold) begin
      if (w_refresh1) r_rs1_val <= wb_value;
      if (w_refresh2) r_rs2_val <= wb_value;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid           = r_valid;
  assign pc_out              = r_pc;
  assign rd_out              = r_pkt.rd;
  assign rd_write_out        = r_valid & r_pkt.rd_write;
  assign rs1_out             = r_pkt.rs1;
  assign rs2_out             = r_pkt.rs2;
  assign rs1_value_out       = r_rs1_val;
  assign rs2_value_out       = r_rs2_val;
  assign imm_value_out       = r_imm;
  assign funct3_out          = r_pkt.funct3;
  assign funct7_out          = r_pkt.funct7;
  assign opclass_out         = r_pkt.opclass;
  assign mem_read_out        = r_valid & r_pkt.mem_read;
  assign mem_write_out       = r_valid & r_pkt.mem_write;
  assign mem_zero_extend_out = r_pkt.mem_zero_extend;
  assign mem_width_out       = r_pkt.mem_width;
  assign branch_out          = r_valid & r_pkt.branch;
  assign jump_out            = r_valid & r_pkt.jump;
  assign bp_taken_out        = r_pkt.bp_taken;
  assign illegal_out         = r_pkt.illegal;

endmodule
